// File: rtl/serial_tx_pkg.sv
// serial_tx_pkg: shared types and constants for the serial word scheduler
package serial_tx_pkg;
  localparam int WORD_W = 32;
  localparam int BIT_IDX_W = 5;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  function automatic int id_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant search starting at a pointer that advances past each winner
module rr_arbiter
  import serial_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);
  logic [IW-1:0] ptr;
  // descending offsets so the nearest requester at or after ptr is assigned last and wins
  always_comb begin
    int j;
    j = 0;
    grant = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        idx = IW'(j);
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr <= '0;
    else if (adv) ptr <= (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin word loader and 32-cycle bit sequencer for a shared shifter
module serial_tx_scheduler
  import serial_tx_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_CYCLES = 0,
  localparam int IW = id_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      sched_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ser_en,
  output logic [WORD_W-1:0]         ser_data,
  output logic                      bit_valid,
  output logic [BIT_IDX_W-1:0]      bit_idx,
  output logic [IW-1:0]             word_src,
  output logic                      word_done,
  output logic                      busy
);
  state_t state, nxt;
  logic [BIT_IDX_W-1:0] bit_cnt, cnt_n;
  logic [3:0] gap_cnt, gap_n;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0] win;
  logic load;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk(clk),
    .rst(rst),
    .req(req_valid),
    .adv(load),
    .grant(grant),
    .idx(win)
  );
  // registered outputs are computed from next-state so they line up with the shifter output
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bit_cnt <= '0;
      gap_cnt <= '0;
      word_src <= '0;
      bit_valid <= 1'b0;
      bit_idx <= '0;
      word_done <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      bit_cnt <= cnt_n;
      gap_cnt <= gap_n;
      if (load) word_src <= win;
      bit_valid <= nxt == SHIFT;
      bit_idx <= nxt == SHIFT ? cnt_n : '0;
      word_done <= nxt == SHIFT && cnt_n == '0;
      busy <= nxt != IDLE;
    end
  always_comb begin
    nxt = state;
    cnt_n = bit_cnt;
    gap_n = gap_cnt;
    case (state)
      IDLE:
        if (load) begin
          nxt = SHIFT;
          cnt_n = BIT_IDX_W'(WORD_W - 1);
        end
      SHIFT:
        if (bit_cnt != '0) cnt_n = bit_cnt - 1'b1;
        else if (load) cnt_n = BIT_IDX_W'(WORD_W - 1);
        else if (GAP_CYCLES > 0) begin
          nxt = GAP;
          gap_n = 4'(GAP_CYCLES - 1);
        end else nxt = IDLE;
      GAP:
        if (gap_cnt == '0) nxt = IDLE;
        else gap_n = gap_cnt - 1'b1;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    load = sched_en && |req_valid && !rst &&
           (state == IDLE || (state == SHIFT && bit_cnt == '0 && GAP_CYCLES == 0));
    ser_en = load;
    req_ready = load ? grant : '0;
    ser_data = load ? req_data[int'(win)*WORD_W +: WORD_W] : '0;
  end
endmodule

// File: tb/tb_serial_tx_scheduler.sv
// tb_serial_tx_scheduler: directed checks of grants, bit sequencing, gaps and reset
module tb_serial_tx_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sched_en = 1'b0;
  logic [3:0] req_valid = '0, req_valid_g = '0;
  logic [127:0] req_data;
  logic [3:0] req_ready, req_ready_g;
  logic ser_en, ser_en_g, bit_valid, bit_valid_g, word_done, word_done_g, busy, busy_g;
  logic [31:0] ser_data, ser_data_g, sr;
  logic [4:0] bit_idx, bit_idx_g;
  logic [1:0] word_src, word_src_g;
  logic bit_out;
  logic [31:0] w [4] = '{32'hA5A50F0F, 32'h12345678, 32'hDEADBEEF, 32'h80000001};
  int passed = 0, total = 0;
  serial_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .ser_en(ser_en), .ser_data(ser_data), .bit_valid(bit_valid),
    .bit_idx(bit_idx), .word_src(word_src), .word_done(word_done), .busy(busy)
  );
  serial_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(3)) dut_g (
    .clk(clk), .rst(rst), .sched_en(sched_en), .req_valid(req_valid_g), .req_data(req_data),
    .req_ready(req_ready_g), .ser_en(ser_en_g), .ser_data(ser_data_g), .bit_valid(bit_valid_g),
    .bit_idx(bit_idx_g), .word_src(word_src_g), .word_done(word_done_g), .busy(busy_g)
  );
  initial forever #5 clk = ~clk;
  // stand-in for the downstream shifter: load on ser_en, shift MSB-first otherwise
  always @(posedge clk) sr <= ser_en ? ser_data : {sr[30:0], 1'b0};
  assign bit_out = sr[31];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic load_chk(input logic [3:0] g, input logic [31:0] d);
    #1;
    chk("ser_en", 32'(ser_en), 32'd1);
    chk("req_ready", 32'(req_ready), 32'(g));
    chk("ser_data", ser_data, d);
  endtask
  task automatic run(input int src, input logic [31:0] d, input int a, input int b);
    for (int i = a; i <= b; i++) begin
      step();
      chk("bit_valid", 32'(bit_valid), 32'd1);
      chk("bit_idx", 32'(bit_idx), 32'(32 - i));
      chk("word_src", 32'(word_src), 32'(src));
      chk("word_done", 32'(word_done), 32'(i == 32));
      chk("ser_bit", 32'(bit_out), 32'(d[32-i]));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    req_data = {w[3], w[2], w[1], w[0]};
    sched_en = 1'b1;
    req_valid = 4'b0001;
    repeat (2) step();
    chk("rst_ser_en", 32'(ser_en), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("rst_bit_idx", 32'(bit_idx), 32'd0);
    chk("rst_word_done", 32'(word_done), 32'd0);
    // single word from source 0
    rst = 1'b0;
    load_chk(4'b0001, w[0]);
    run(0, w[0], 1, 1);
    req_valid = 4'b0000;
    run(0, w[0], 2, 32);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_bit_valid", 32'(bit_valid), 32'd0);
    chk("idle_word_done", 32'(word_done), 32'd0);
    chk("idle_ser_en", 32'(ser_en), 32'd0);
    // all sources valid, back-to-back rotation from a fresh pointer
    rst = 1'b1;
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      load_chk(4'b0001 << k, w[k]);
      run(k, w[k], 1, 32);
    end
    load_chk(4'b0001, w[0]);
    run(0, w[0], 1, 22);
    sched_en = 1'b0;
    run(0, w[0], 23, 32);
    #1;
    chk("hold_ser_en", 32'(ser_en), 32'd0);
    chk("hold_req_ready", 32'(req_ready), 32'd0);
    step();
    chk("hold_busy", 32'(busy), 32'd0);
    chk("hold_bit_valid", 32'(bit_valid), 32'd0);
    step();
    chk("hold_ser_en2", 32'(ser_en), 32'd0);
    sched_en = 1'b1;
    load_chk(4'b0010, w[1]);
    // reset mid-word, then source 2 alone
    run(1, w[1], 1, 1);
    req_valid = 4'b0100;
    run(1, w[1], 2, 12);
    rst = 1'b1;
    #1;
    chk("arst_bit_valid", 32'(bit_valid), 32'd0);
    chk("arst_bit_idx", 32'(bit_idx), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_word_src", 32'(word_src), 32'd0);
    chk("arst_ser_en", 32'(ser_en), 32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd0);
    step();
    rst = 1'b0;
    load_chk(4'b0100, w[2]);
    // wrap-around grant to source 1, then pointer left at 2
    run(2, w[2], 1, 1);
    req_valid = 4'b0010;
    run(2, w[2], 2, 32);
    load_chk(4'b0010, w[1]);
    run(1, w[1], 1, 32);
    load_chk(4'b0010, w[1]);
    run(1, w[1], 1, 1);
    req_valid = 4'b1110;
    run(1, w[1], 2, 32);
    load_chk(4'b0100, w[2]);
    run(2, w[2], 1, 1);
    req_valid = 4'b0000;
    run(2, w[2], 2, 32);
    step();
    chk("end_busy", 32'(busy), 32'd0);
    // gap instance: period 36 with 4 invalid cycles between words
    req_valid_g = 4'b0001;
    #1;
    chk("gap_ser_en", 32'(ser_en_g), 32'd1);
    chk("gap_req_ready", 32'(req_ready_g), 32'd1);
    for (int p = 0; p < 2; p++)
      for (int n = 1; n <= 36; n++) begin
        step();
        chk("gap_load", 32'(ser_en_g), 32'(n == 36));
        chk("gap_bit_valid", 32'(bit_valid_g), 32'(n <= 32));
        chk("gap_word_done", 32'(word_done_g), 32'(n == 32));
        chk("gap_busy", 32'(busy_g), 32'(n <= 35));
      end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
